reg_file_wb_arbiter: RTL and testbench

Shares the single write port of the 32 x 32-bit register file among NUM_REQ writeback requesters (default: ALU writeback and load writeback) using round-robin arbitration with a valid/ready handshake. The granted write is registered into one write stage that drives the register file's wen/waddr/wdata directly. Sits between the CPU's execute/memory writeback sources and the register file. Optionally forwards the in-flight write to the two read ports.

---
 rtl/reg_file_wb_arbiter_pkg.sv | 16 +
 rtl/reg_file_wb_arbiter_if.sv | 42 ++++
 rtl/reg_file_wb_arbiter_rr_arbiter.sv | 35 +++
 rtl/reg_file_wb_arbiter.sv | 91 +++++++++
 tb/tb_reg_file_wb_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_wb_arbiter_pkg.sv
// Shared register-file constants and the writeback payload type used by the
// reg_file_wb_arbiter slice. Values match the 32 x 32-bit register file.
package reg_file_wb_arbiter_pkg;

    localparam int unsigned REG_NUM     = 32;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned ADDR_WIDTH  = $clog2(REG_NUM);
    localparam int unsigned COUNT_WIDTH = 32;

    // One writeback request as presented to the register file write port.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/reg_file_wb_arbiter_if.sv
// Bus bundle between the writeback requesters / register file and
// reg_file_wb_arbiter. The slave modport is the arbiter's view.
interface reg_file_wb_arbiter_if
    import reg_file_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;

    logic                          wb_wen;
    logic [ADDR_WIDTH-1:0]         wb_waddr;
    logic [DATA_WIDTH-1:0]         wb_wdata;
    logic [COUNT_WIDTH-1:0]        wb_count;

    logic [ADDR_WIDTH-1:0]         raddr1;
    logic [ADDR_WIDTH-1:0]         raddr2;
    logic [DATA_WIDTH-1:0]         rf_rdata1;
    logic [DATA_WIDTH-1:0]         rf_rdata2;
    logic [DATA_WIDTH-1:0]         rdata1;
    logic [DATA_WIDTH-1:0]         rdata2;

    modport slave (
        input  req_valid, req_waddr, req_wdata,
        input  raddr1, raddr2, rf_rdata1, rf_rdata2,
        output req_ready,
        output wb_wen, wb_waddr, wb_wdata, wb_count,
        output rdata1, rdata2
    );

    modport master (
        output req_valid, req_waddr, req_wdata,
        output raddr1, raddr2, rf_rdata1, rf_rdata2,
        input  req_ready,
        input  wb_wen, wb_waddr, wb_wdata, wb_count,
        input  rdata1, rdata2
    );

endinterface

// File: rtl/reg_file_wb_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant. Searches the valid
// vector circularly starting at ptr and grants the first set bit.
module reg_file_wb_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [PTR_W-1:0]   grant_idx_c,
    output logic               grant_any_c
);

    int unsigned idx;

    // Circular first-set search from ptr; first hit wins, so grant is one-hot.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        idx         = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any_c && valid[PTR_W'(idx)]) begin
                grant_any_c             = 1'b1;
                grant_idx_c             = PTR_W'(idx);
                grant_c[PTR_W'(idx)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// reg_file_wb_arbiter: shares the register file write port among NUM_REQ
// writeback requesters with round-robin arbitration and a single registered
// write stage. Address-0 writes are accepted but never written or counted.
// Optional feature macro: RF_WB_FWD_EN forwards the in-flight write stage to
// both read ports.
module reg_file_wb_arbiter
    import reg_file_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_file_wb_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_next_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [PTR_W-1:0]   grant_idx_c;
    logic               grant_any_c;
    wb_req_t            sel_c;

    reg_file_wb_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .valid       (bus.req_valid),
        .ptr         (rr_ptr),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .grant_any_c (grant_any_c)
    );

    // Ready is exactly the one-hot grant; it never feeds back into valid.
    assign bus.req_ready = grant_c;

    // Pointer moves to the requester after the one just granted.
    assign ptr_next_c = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0
                                                            : grant_idx_c + PTR_W'(1);

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_c.waddr = bus.req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_c.wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Write stage, round-robin pointer and issued-write counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            bus.wb_wen   <= 1'b0;
            bus.wb_waddr <= '0;
            bus.wb_wdata <= '0;
            bus.wb_count <= '0;
        end else begin
            if (grant_any_c) begin
                rr_ptr       <= ptr_next_c;
                bus.wb_waddr <= sel_c.waddr;
                bus.wb_wdata <= sel_c.wdata;
                bus.wb_wen   <= (sel_c.waddr != '0);
            end else begin
                bus.wb_wen   <= 1'b0;
            end
            if (bus.wb_wen) begin
                bus.wb_count <= bus.wb_count + COUNT_WIDTH'(1);
            end
        end
    end

`ifdef RF_WB_FWD_EN
    // Bypass the write stage into the read ports; x0 is never forwarded.
    assign bus.rdata1 = (bus.wb_wen && (bus.wb_waddr == bus.raddr1) && (bus.raddr1 != '0))
                        ? bus.wb_wdata : bus.rf_rdata1;
    assign bus.rdata2 = (bus.wb_wen && (bus.wb_waddr == bus.raddr2) && (bus.raddr2 != '0))
                        ? bus.wb_wdata : bus.rf_rdata2;
`else
    // No bypass: the datapath stalls one cycle on a read-after-write match.
    logic unused_raddr_c;
    assign unused_raddr_c = ^{bus.raddr1, bus.raddr2};
    assign bus.rdata1     = bus.rf_rdata1;
    assign bus.rdata2     = bus.rf_rdata2;
`endif

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Directed testbench for reg_file_wb_arbiter (NUM_REQ = 2). Inputs change on
// the falling edge; outputs are sampled 1 time unit after an edge.
module tb_reg_file_wb_arbiter;
    import reg_file_wb_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    localparam logic [1:0] EXP_GNT   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    localparam logic [4:0] EXP_WADDR [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    localparam logic [31:0] EXP_WDATA [4] = '{32'h0000_0111, 32'h0000_0222,
                                             32'h0000_0111, 32'h0000_0222};

    reg_file_wb_arbiter_if #(.NUM_REQ(2)) bus ();

    reg_file_wb_arbiter #(.NUM_REQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_waddr = '0;
        bus.req_wdata = '0;
        bus.raddr1    = '0;
        bus.raddr2    = '0;
        bus.rf_rdata1 = '0;
        bus.rf_rdata2 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.req_valid = 2'b11;
        bus.req_waddr = {5'd2, 5'd1};
        bus.req_wdata = {32'hBBBB_0002, 32'hAAAA_0001};
        @(negedge clk);
        tests_run++;
        if (bus.wb_wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wen: got %b expected 0", bus.wb_wen);
        end
        tests_run++;
        if (bus.wb_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d expected 0", bus.wb_count);
        end
        tests_run++;
        if (bus.req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 01", bus.req_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (bus.wb_wen !== 1'b1 || bus.wb_waddr !== 5'd1 || bus.wb_wdata !== 32'hAAAA_0001) begin
            tests_failed++;
            $display("FAIL reset_first_write: got wen=%b addr=%0d data=%h expected wen=1 addr=1 data=aaaa0001",
                     bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
        end
        tests_run++;
        if (bus.req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_ptr_advance: got ready=%b expected 10", bus.req_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid = 2'b10;
        bus.req_waddr = {5'd5, 5'd0};
        bus.req_wdata = {32'hDEAD_BEEF, 32'h0};
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_ready: got %b expected 10", bus.req_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.wb_wen !== 1'b1 || bus.wb_waddr !== 5'd5 || bus.wb_wdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL single_write: got wen=%b addr=%0d data=%h expected wen=1 addr=5 data=deadbeef",
                     bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_idle_ready: got %b expected 00", bus.req_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.wb_wen !== 1'b0 || bus.wb_count !== 32'd1 || bus.wb_wdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL single_after: got wen=%b count=%0d data=%h expected wen=0 count=1 data=deadbeef",
                     bus.wb_wen, bus.wb_count, bus.wb_wdata);
        end
    endtask

    task automatic test_contention();
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_waddr = {5'd2, 5'd1};
        bus.req_wdata = {32'h0000_0222, 32'h0000_0111};
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++;
            if (bus.req_ready !== EXP_GNT[k]) begin
                tests_failed++;
                $display("FAIL contention_grant[%0d]: got %b expected %b", k, bus.req_ready, EXP_GNT[k]);
            end
            @(posedge clk); #1;
            tests_run++;
            if (bus.wb_wen !== 1'b1 || bus.wb_waddr !== EXP_WADDR[k] || bus.wb_wdata !== EXP_WDATA[k]) begin
                tests_failed++;
                $display("FAIL contention_write[%0d]: got wen=%b addr=%0d data=%h expected wen=1 addr=%0d data=%h",
                         k, bus.wb_wen, bus.wb_waddr, bus.wb_wdata, EXP_WADDR[k], EXP_WDATA[k]);
            end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        tests_run++;
        if (bus.wb_count !== 32'd4 || bus.wb_wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL contention_count: got count=%0d wen=%b expected count=4 wen=0",
                     bus.wb_count, bus.wb_wen);
        end
    endtask

    task automatic test_same_addr();
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_waddr = {5'd9, 5'd9};
        bus.req_wdata = {32'h1111_1111, 32'h0000_0000};
        @(posedge clk); #1;
        tests_run++;
        if (bus.wb_waddr !== 5'd9 || bus.wb_wdata !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL same_addr_first: got addr=%0d data=%h expected addr=9 data=00000000",
                     bus.wb_waddr, bus.wb_wdata);
        end
        @(negedge clk);
        bus.req_valid = 2'b10;
        @(posedge clk); #1;
        tests_run++;
        if (bus.wb_wen !== 1'b1 || bus.wb_waddr !== 5'd9 || bus.wb_wdata !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL same_addr_last: got wen=%b addr=%0d data=%h expected wen=1 addr=9 data=11111111",
                     bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
        end
    endtask

    task automatic test_zero_addr();
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_waddr = {5'd0, 5'd0};
        bus.req_wdata = {32'h0, 32'h0000_1234};
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL zero_ready: got %b expected 01", bus.req_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.wb_wen !== 1'b0 || bus.wb_waddr !== 5'd0 || bus.wb_wdata !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL zero_stage: got wen=%b addr=%0d data=%h expected wen=0 addr=0 data=00001234",
                     bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
        end
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_waddr = {5'd4, 5'd3};
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL zero_ptr_advance: got ready=%b expected 10", bus.req_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.wb_count !== 32'd0 || bus.wb_waddr !== 5'd4 || bus.wb_wen !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_count: got count=%0d addr=%0d wen=%b expected count=0 addr=4 wen=1",
                     bus.wb_count, bus.wb_waddr, bus.wb_wen);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] exp1;
        logic [31:0] exp2;
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_waddr = {5'd0, 5'd7};
        bus.req_wdata = {32'h0, 32'hA5A5_A5A5};
        bus.raddr1    = 5'd7;
        bus.raddr2    = 5'd0;
        bus.rf_rdata1 = 32'h0;
        bus.rf_rdata2 = 32'h5555_AAAA;
        @(posedge clk); #1;
`ifdef RF_WB_FWD_EN
        exp1 = 32'hA5A5_A5A5;
`else
        exp1 = 32'h0;
`endif
        tests_run++;
        if (bus.rdata1 !== exp1 || bus.rdata2 !== 32'h5555_AAAA) begin
            tests_failed++;
            $display("FAIL fwd_match: got rdata1=%h rdata2=%h expected rdata1=%h rdata2=5555aaaa",
                     bus.rdata1, bus.rdata2, exp1);
        end
        bus.raddr2    = 5'd7;
        bus.rf_rdata2 = 32'h0000_0022;
`ifdef RF_WB_FWD_EN
        exp2 = 32'hA5A5_A5A5;
`else
        exp2 = 32'h0000_0022;
`endif
        #1;
        tests_run++;
        if (bus.rdata2 !== exp2) begin
            tests_failed++;
            $display("FAIL fwd_port2: got %h expected %h", bus.rdata2, exp2);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        tests_run++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0000_0022) begin
            tests_failed++;
            $display("FAIL fwd_idle: got rdata1=%h rdata2=%h expected 00000000 00000022",
                     bus.rdata1, bus.rdata2);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_waddr = {5'd2, 5'd1};
        bus.req_wdata = {32'h0000_0222, 32'h0000_0111};
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.wb_wen !== 1'b1 || bus.wb_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL mid_pre: got wen=%b count=%0d expected wen=1 count=2", bus.wb_wen, bus.wb_count);
        end
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.wb_wen !== 1'b0 || bus.wb_count !== 32'd0 || bus.wb_waddr !== 5'd0 || bus.req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL mid_reset: got wen=%b count=%0d addr=%0d ready=%b expected wen=0 count=0 addr=0 ready=01",
                     bus.wb_wen, bus.wb_count, bus.wb_waddr, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (bus.wb_wen !== 1'b1 || bus.wb_waddr !== 5'd1) begin
            tests_failed++;
            $display("FAIL mid_restart: got wen=%b addr=%0d expected wen=1 addr=1", bus.wb_wen, bus.wb_waddr);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_contention();
        test_same_addr();
        test_zero_addr();
        test_forwarding();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
